// File: rtl/pp_pkg.sv
// Shared widths and types for the log-domain partial-product generator.
// EXP_W must be wide enough to hold IMG_W, which is the largest rounded exponent.
package pp_pkg;

    localparam int IMG_W = 8;
    localparam int WGT_W = 4;
    localparam int EXP_W = 5;
    localparam int PP_W  = WGT_W + 1;
    localparam int POS_W = $clog2(IMG_W);

    typedef logic [IMG_W-1:0] image_t;
    typedef logic [WGT_W-1:0] weight_t;
    typedef logic [PP_W-1:0]  pp_t;
    typedef logic [EXP_W-1:0] exp_t;
    typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/lod8.sv
// Leading-one detector for an 8-bit activation.
// Reports the index of the most significant set bit, and a flag when the value is zero.
module lod8
    import pp_pkg::*;
(
    input  logic [IMG_W-1:0] value,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scanning upward from the LSB lets the highest set bit have the final say.
    always_comb begin
        pos = '0;
        for (int i = 0; i < IMG_W; i++) begin
            if (value[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/pp_generator.sv
// Rounds the activation to the nearest power of two and sign-extends the weight,
// registering the exponent/mantissa pair for the shift-accumulate stage.
module pp_generator
    import pp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IMG_W-1:0] image,
    input  logic [WGT_W-1:0] weight,
    output logic [PP_W-1:0]  signed_pp,
    output logic [EXP_W-1:0] exp
);

    pos_t       lead_pos;
    logic       image_zero;
    logic       round_bit;
    logic [3:0] exp_sum;
    exp_t       exp_next;
    pp_t        pp_next;

    lod8 u_lod8 (
        .value (image),
        .pos   (lead_pos),
        .zero  (image_zero)
    );

    // Round half up on the bit just below the leading one; image==1 has no such bit.
    always_comb begin
        round_bit = 1'b0;
        if (lead_pos != '0) round_bit = image[lead_pos - pos_t'(1)];
    end

    assign exp_sum  = {1'b0, lead_pos} + {3'b000, round_bit};
    assign exp_next = image_zero ? '0 : {{(EXP_W-4){1'b0}}, exp_sum};
    assign pp_next  = image_zero ? '0 : {weight[WGT_W-1], weight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signed_pp <= '0;
            exp       <= '0;
        end else begin
            signed_pp <= pp_next;
            exp       <= exp_next;
        end
    end

endmodule

// File: tb/tb_pp_generator.sv
// Self-checking bench for pp_generator: directed corner cases, an exhaustive sweep
// with an asynchronous reset pulse, and random pairs against an arithmetic model.
module tb_pp_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] image = '0;
    logic [3:0] weight = '0;
    logic [4:0] signed_pp;
    logic [4:0] exp;

    int n_checks = 0;
    int n_fail   = 0;

    pp_generator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .image     (image),
        .weight    (weight),
        .signed_pp (signed_pp),
        .exp       (exp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (image=%0d weight=%0d)",
                     tag, actual, expected, image, weight);
        end
    endtask

    // Nearest power of two, ties rounded up on the bit below the leading one.
    function automatic int model_exp(input int img);
        int p;
        if (img == 0) return 0;
        p = 0;
        while ((2 ** (p + 1)) <= img) p++;
        if (p >= 1 && img >= (2 ** p) + (2 ** (p - 1))) return p + 1;
        return p;
    endfunction

    function automatic int model_pp(input int img, input int wgt);
        int w;
        if (img == 0) return 0;
        w = (wgt >= 8) ? wgt - 16 : wgt;
        return (w + 32) % 32;
    endfunction

    task automatic step(input int img, input int wgt, input string tag);
        @(negedge clk);
        image  = 8'(img);
        weight = 4'(wgt);
        @(posedge clk);
        #1;
        check({tag, ".exp"}, int'(exp), model_exp(img));
        check({tag, ".pp"},  int'(signed_pp), model_pp(img, wgt));
    endtask

    initial begin
        // Reset held with arbitrary inputs across several edges.
        rst_n  = 1'b0;
        image  = 8'hC3;
        weight = 4'b1001;
        repeat (3) @(posedge clk);
        #1;
        check("rst.exp", int'(exp), 0);
        check("rst.pp",  int'(signed_pp), 0);

        @(negedge clk);
        image  = 8'b1101_1010;
        weight = 4'b1010;
        rst_n  = 1'b1;
        #1;
        check("rel_noedge.exp", int'(exp), 0);
        check("rel_noedge.pp",  int'(signed_pp), 0);
        @(posedge clk);
        #1;
        check("first.exp", int'(exp), 8);
        check("first.pp",  int'(signed_pp), 5'b11010);

        step(8'b1010_1010, 4'b1010, "t3a");
        check("t3a.const", int'(exp), 7);
        step(8'b1010_1010, 4'b0011, "t3b");
        check("t3b.const", int'(signed_pp), 5'b00011);
        step(8'h00, 4'b0111, "zero_img");
        check("zero_img.const", int'(signed_pp), 0);
        step(8'h01, 4'b1000, "one_img");
        check("one_img.const", int'(signed_pp), 5'b11000);
        step(8'hFF, 4'b0101, "ff");
        check("ff.const", int'(exp), 8);
        step(8'b0110_0000, 4'b0001, "x60");
        check("x60.const", int'(exp), 7);
        step(8'b0100_0000, 4'b0000, "x40");
        check("x40.const", int'(exp), 6);
        check("zero_wgt.const", int'(signed_pp), 0);

        for (int i = 0; i < 4096; i++) begin
            step(i % 256, i / 256, "sweep");
            if (i == 2051) begin
                #1 rst_n = 1'b0;
                #1;
                check("async_rst.exp", int'(exp), 0);
                check("async_rst.pp",  int'(signed_pp), 0);
                #1 rst_n = 1'b1;
            end
        end

        for (int i = 0; i < 500; i++) begin
            step(int'($urandom_range(255)), int'($urandom_range(15)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
